// File: rtl/approx_mult_err_accum_pkg.sv
// Shared types and helpers for the approximate-multiplier error evaluator.
// Latency: none (types, constants and a combinational helper).
// Backpressure: not applicable.
package approx_eval_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_t;

  // |x - y| through a 17-bit signed difference; the magnitude always fits in 16 bits.
  function automatic logic [PROD_W-1:0] abs_diff16(input logic [PROD_W-1:0] x,
                                                   input logic [PROD_W-1:0] y);
    logic signed [PROD_W:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d[PROD_W]) return PROD_W'(-d);
    else           return PROD_W'(d);
  endfunction

endpackage

// File: rtl/approx_mult_err_accum_if.sv
// Sample bus carrying operands and the approximate product into the evaluator.
// Latency: none (bundle of wires).
// Backpressure: a sample moves only on a cycle with in_valid && in_ready.
interface approx_mult_err_accum_if;
  import approx_eval_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [PROD_W-1:0] r_approx;

  modport master (output in_valid, a, b, r_approx, input in_ready);
  modport slave  (input in_valid, a, b, r_approx, output in_ready);

endinterface

// File: rtl/approx_err_calc.sv
// S1/S2 pipeline: exact product, then error distance against the approximate product.
// Latency: 2 cycles from transfer to a valid ED at s2.
// Backpressure: none; one sample per cycle always advances.
module approx_err_calc
  import approx_eval_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_r,
  output logic              s1_vld,
  output logic              s2_vld,
  output logic [OP_W-1:0]   s2_a,
  output logic [OP_W-1:0]   s2_b,
  output logic [PROD_W-1:0] s2_ed
);

  logic [OP_W-1:0]   s1_a;
  logic [OP_W-1:0]   s1_b;
  logic [PROD_W-1:0] s1_r;
  logic [PROD_W-1:0] s1_exact;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_r     <= '0;
      s1_exact <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_r     <= in_r;
        s1_exact <= PROD_W'(in_a) * PROD_W'(in_b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_ed  <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_a  <= s1_a;
        s2_b  <= s1_b;
        s2_ed <= abs_diff16(s1_exact, s1_r);
      end
    end
  end

endmodule

// File: rtl/approx_mult_err_accum.sv
// Error-metric accumulator for an 8x8 approximate multiplier over a programmed sample count.
// Latency: metrics reflect a sample 3 cycles after its transfer; done 1 cycle after drain.
// Backpressure: in_ready drops once num_samples are accepted; no stalls inside the pipeline.
module approx_mult_err_accum
  import approx_eval_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_samples,
  approx_mult_err_accum_if.slave  smp,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_count,
  output logic [SUM_W-1:0]        ed_sum,
  output logic                    sum_sat,
  output logic [PROD_W-1:0]       ed_max,
  output logic [OP_W-1:0]         worst_a,
  output logic [OP_W-1:0]         worst_b
);

  eval_state_t       state_q;
  eval_state_t       state_d;
  logic [CNT_W-1:0]  num_lat_q;
  logic [CNT_W-1:0]  accepted_q;
  logic              clear_metrics;
  logic              rdy;
  logic              xfer;

  logic              s1_vld;
  logic              s2_vld;
  logic [OP_W-1:0]   s2_a;
  logic [OP_W-1:0]   s2_b;
  logic [PROD_W-1:0] s2_ed;
  logic              pipe_busy;
  logic [SUM_W:0]    sum_ext;

  assign rdy          = (state_q == ST_RUN) && (accepted_q < num_lat_q);
  assign smp.in_ready = rdy;
  assign xfer         = smp.in_valid && rdy;
  assign pipe_busy    = s1_vld || s2_vld;
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);

  // One extra bit catches the carry out so the sum can clamp instead of wrapping.
  assign sum_ext = {1'b0, ed_sum} + (SUM_W+1)'(s2_ed);

  approx_err_calc u_calc (
    .clk    (clk),
    .rst    (rst),
    .in_vld (xfer),
    .in_a   (smp.a),
    .in_b   (smp.b),
    .in_r   (smp.r_approx),
    .s1_vld (s1_vld),
    .s2_vld (s2_vld),
    .s2_a   (s2_a),
    .s2_b   (s2_b),
    .s2_ed  (s2_ed)
  );

  always_comb begin
    state_d       = state_q;
    clear_metrics = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_metrics = 1'b1;
          state_d       = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accepted_q == num_lat_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat_q  <= '0;
      accepted_q <= '0;
    end else if (clear_metrics) begin
      num_lat_q  <= num_samples;
      accepted_q <= '0;
    end else if (xfer) begin
      accepted_q <= accepted_q + CNT_W'(1);
    end
  end

  // Start only fires in IDLE/DONE, where the pipeline is already empty.
  always_ff @(posedge clk) begin
    if (rst || clear_metrics) begin
      err_count <= '0;
      ed_sum    <= '0;
      sum_sat   <= 1'b0;
      ed_max    <= '0;
      worst_a   <= '0;
      worst_b   <= '0;
    end else if (s2_vld) begin
      if (s2_ed != '0) err_count <= err_count + CNT_W'(1);
      if (sum_ext[SUM_W]) begin
        ed_sum  <= '1;
        sum_sat <= 1'b1;
      end else begin
        ed_sum <= sum_ext[SUM_W-1:0];
      end
      // Strictly greater keeps the earliest sample on a tie.
      if (s2_ed > ed_max) begin
        ed_max  <= s2_ed;
        worst_a <= s2_a;
        worst_b <= s2_b;
      end
    end
  end

endmodule

// File: doc/approx_mult_err_accum.md
Name: approx_mult_err_accum

Overview:
- Sequential error-metric stage directly downstream of the 8x8 approximate multipliers.
- Consumes operand pairs (A, B) together with the approximate product R.
- Internally recomputes the exact product, measures the error distance (ED), and accumulates four statistics over a programmed sample count: error count, ED sum, max ED and the worst-case operands.
- Used for on-chip characterisation of each approximate multiplier variant without host-side post-processing.

Parameters:
- CNT_W, 16, width of the sample-count input and of the error/accepted counters
- SUM_W, 32, width of the ED-sum accumulator (saturating)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches num_samples and clears all metrics
- num_samples  in  CNT_W  number of samples to accept in this run
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample this cycle
- a  in  8  operand A (unsigned)
- b  in  8  operand B (unsigned)
- r_approx  in  16  approximate product from the multiplier under test
- busy  out  1  run in progress (RUN or DRAIN)
- done  out  1  metrics valid; held until the next start or rst
- err_count  out  CNT_W  number of samples with ED != 0
- ed_sum  out  SUM_W  sum of |exact - r_approx|, saturating
- sum_sat  out  1  set once ed_sum has saturated
- ed_max  out  16  largest ED seen
- worst_a  out  8  A operand of the first sample that reached ed_max
- worst_b  out  8  B operand of the same sample

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: every output is 0; the FSM is in IDLE; the pipeline is empty.
- rst during any state aborts the run. Any partial metrics are discarded.
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE: on start, go to RUN, or straight to DONE if num_samples==0.
  - RUN: stay until accepted == num_samples, then go to DRAIN.
  - DRAIN: stay until pipeline valid bits are all 0, then go to DONE.
  - DONE: on start, restart exactly as from IDLE.
- start is ignored while in RUN or DRAIN.
- Every start clears err_count, ed_sum, sum_sat, ed_max, worst_a/b and the accepted counter.
- in_ready = (state==RUN) && (accepted < num_samples_latched). It is combinational from registered state only, never from in_valid.
- A transfer happens when in_valid && in_ready. The sample is accepted and the accepted counter increments.
- Pipeline (fixed, no backpressure inside):
  - S1 registers a, b and r_approx, plus exact = a*b (16-bit unsigned, max 65025).
  - S2 registers ED = |exact - r_approx|. This needs a 17-bit signed subtract; the magnitude always fits in 16 bits.
  - S3 updates the accumulators.
  - Metrics for a sample are visible 3 cycles after its transfer.
- Accumulator update, applied for each valid S2 result:
  - err_count += (ED != 0).
  - ed_sum += ED, saturating at 2^SUM_W-1. sum_sat is sticky.
  - If ED > ed_max (strictly greater), update ed_max, worst_a and worst_b. On a tie, the first occurrence is kept.
- busy = 1 in RUN and DRAIN. done = 1 only in DONE, asserted the cycle after DRAIN exits.
- Output values are stable while done = 1.
- Back-to-back transfers at 1 sample/cycle must be supported. Gaps in in_valid are tolerated.

Decomposition:
- Shared package approx_eval_pkg holds:
  - FSM state enum (IDLE/RUN/DRAIN/DONE)
  - OP_W = 8 and PROD_W = 16 constants
  - a function abs_diff16
- One natural sub-module: approx_err_calc, the S1/S2 pipeline (exact product and ED with valid bit). The FSM and accumulators stay in the top.

Test Plan:
- Exact stimulus, num_samples=4, pairs (15,15,225), (255,255,65025), (0,7,0), (3,5,15) -> done; err_count=0, ed_sum=0, ed_max=0, worst_a/b=0.
- Errors, num_samples=3, (15,15,r=200), (16,16,r=300), (2,2,r=4) -> err_count=2, ed_sum=25+44=69, ed_max=44, worst_a=16, worst_b=16.
- Tie on max: (10,10,r=90) then (20,1,r=10) -> ED 10 both; ed_max=10, worst_a=10, worst_b=10 (first occurrence kept).
- Handshake: num_samples=2 with in_valid held high for 5 cycles -> exactly 2 transfers; in_ready low from the 3rd cycle; done asserts 3 cycles after the last transfer plus 1 for the DRAIN->DONE transition.
- Saturation with SUM_W=17: 3 samples of (0,0,r=65535) -> ed_sum=131071, sum_sat=1.
- Control: num_samples=0 -> done the cycle after start with all metrics 0. rst asserted in RUN after 1 transfer -> all outputs 0, FSM in IDLE, and a following start with 1 sample yields that sample's metrics only.
